// File: rtl/music_pkg.sv
// Shared constants for the music sequencer: score entry layout, FSM states
// and the semitone divider table.
package music_pkg;

  localparam int DUR_MSB  = 13;
  localparam int DUR_LSB  = 8;
  localparam int NOTE_MSB = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    PLAY  = 2'd3
  } state_e;

  // Octave-0 divider per semitone, A first.
  function automatic logic [8:0] base_div(input logic [3:0] r);
    case (r)
      4'd0:    base_div = 9'd511;
      4'd1:    base_div = 9'd482;
      4'd2:    base_div = 9'd455;
      4'd3:    base_div = 9'd430;
      4'd4:    base_div = 9'd405;
      4'd5:    base_div = 9'd383;
      4'd6:    base_div = 9'd361;
      4'd7:    base_div = 9'd341;
      4'd8:    base_div = 9'd322;
      4'd9:    base_div = 9'd303;
      4'd10:   base_div = 9'd286;
      4'd11:   base_div = 9'd270;
      default: base_div = 9'd0;
    endcase
  endfunction

endpackage

// File: rtl/music_sequencer_note_period.sv
// Combinational fullnote -> half-period (in clocks) conversion with
// saturating octave transpose.
module note_period
  import music_pkg::*;
#(
  parameter int PRESC = 8
) (
  input  logic [5:0]       fullnote,
  input  logic [1:0]       oct_shift,
  output logic [PRESC+9:0] half_period
);

  logic [2:0] oct;
  logic [1:0] rhi;
  logic [3:0] sum;
  logic [2:0] eo;
  logic [8:0] base;
  int         eo_int;
  int         shamt;

  // fullnote/12 == (fullnote>>2)/3, so a 16-way nibble case gives octave and
  // the upper part of the semitone; the low two bits pass straight through.
  always_comb begin
    oct = 3'd0;
    rhi = 2'd0;
    case (fullnote[5:2])
      4'd0:    begin oct = 3'd0; rhi = 2'd0; end
      4'd1:    begin oct = 3'd0; rhi = 2'd1; end
      4'd2:    begin oct = 3'd0; rhi = 2'd2; end
      4'd3:    begin oct = 3'd1; rhi = 2'd0; end
      4'd4:    begin oct = 3'd1; rhi = 2'd1; end
      4'd5:    begin oct = 3'd1; rhi = 2'd2; end
      4'd6:    begin oct = 3'd2; rhi = 2'd0; end
      4'd7:    begin oct = 3'd2; rhi = 2'd1; end
      4'd8:    begin oct = 3'd2; rhi = 2'd2; end
      4'd9:    begin oct = 3'd3; rhi = 2'd0; end
      4'd10:   begin oct = 3'd3; rhi = 2'd1; end
      4'd11:   begin oct = 3'd3; rhi = 2'd2; end
      4'd12:   begin oct = 3'd4; rhi = 2'd0; end
      4'd13:   begin oct = 3'd4; rhi = 2'd1; end
      4'd14:   begin oct = 3'd4; rhi = 2'd2; end
      4'd15:   begin oct = 3'd5; rhi = 2'd0; end
      default: begin oct = 3'd0; rhi = 2'd0; end
    endcase

    sum = {1'b0, oct} + {2'b00, oct_shift};
    if (sum > 4'd7) begin
      eo = 3'd7;
    end else begin
      eo = sum[2:0];
    end

    eo_int = int'(eo);
    if (eo_int > PRESC) begin
      shamt = 0;
    end else begin
      shamt = PRESC - eo_int;
    end

    base        = base_div({rhi, fullnote[1:0]});
    // One bit wider than the base+1 value so the A/octave-0 case (512) fits.
    half_period = (PRESC+10)'({1'b0, base} + 10'd1) << shamt;
  end

endmodule

// File: rtl/music_sequencer.sv
// Score-ROM driven tone sequencer: fetches duration/note entries, plays each
// as a square wave with a leading articulation gap, supports pause/stop/loop.
module music_sequencer
  import music_pkg::*;
#(
  parameter int SCORE_AW = 8,
  parameter int TICK_DIV = 4194304,
  parameter int GAP_CYC  = 262144,
  parameter int PRESC    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                pause,
  input  logic                loop_en,
  input  logic [1:0]          oct_shift,
  output logic [SCORE_AW-1:0] score_addr,
  input  logic [15:0]         score_data,
  output logic                speaker,
  output logic                busy,
  output logic                done,
  output logic [5:0]          cur_note
);

  localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW   = $clog2(GAP_CYC + 1);
  localparam int HP_W = PRESC + 10;

  state_e              state_q, state_d;
  logic [SCORE_AW-1:0] addr_q, addr_d;
  logic [TW-1:0]       tick_q, tick_d;
  logic [5:0]          rem_q, rem_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic [HP_W-1:0]     phase_q, phase_d;
  logic [5:0]          note_q, note_d;
  logic                tone_q, tone_d;
  logic                speaker_q, speaker_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [5:0]          cur_note_q, cur_note_d;

  logic                frozen;
  logic [5:0]          dur_in;
  logic [HP_W-1:0]     half_period;
  logic                unused_score_bits;

  assign dur_in            = score_data[DUR_MSB:DUR_LSB];
  assign unused_score_bits = ^{score_data[15:14], score_data[7:6]};

  note_period #(.PRESC(PRESC)) u_period (
    .fullnote    (note_q),
    .oct_shift   (oct_shift),
    .half_period (half_period)
  );

  // Next-state, counters and registered output values.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tick_d  = tick_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    phase_d = phase_q;
    note_d  = note_q;
    tone_d  = tone_q;
    done_d  = 1'b0;
    frozen  = pause && (state_q != IDLE);

    if (stop) begin
      state_d = IDLE;
      addr_d  = '0;
      tone_d  = 1'b0;
    end else if (frozen) begin
      state_d = state_q;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = FETCH;
            addr_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end
        FETCH: state_d = LOAD;
        LOAD: begin
          if (dur_in == 6'd0) begin
            addr_d = '0;
            if (loop_en) begin
              state_d = FETCH;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            note_d  = score_data[NOTE_MSB:0];
            rem_d   = dur_in;
            tick_d  = '0;
            gap_d   = '0;
            phase_d = '0;
            tone_d  = 1'b0;
            state_d = PLAY;
          end
        end
        PLAY: begin
          // Phase runs only once the gap has elapsed; the reload on the gap's
          // last clock makes the first edge land exactly at GAP_CYC.
          if (gap_q < GW'(GAP_CYC - 1)) begin
            gap_d = gap_q + GW'(1);
          end else begin
            gap_d = GW'(GAP_CYC);
            if (note_q == 6'd0) begin
              tone_d = 1'b0;
            end else if (phase_q <= HP_W'(1)) begin
              phase_d = half_period;
              tone_d  = ~tone_q;
            end else begin
              phase_d = phase_q - HP_W'(1);
            end
          end

          if (tick_q == TW'(TICK_DIV - 1)) begin
            tick_d = '0;
            rem_d  = rem_q - 6'd1;
            if (rem_q == 6'd1) begin
              state_d = FETCH;
              addr_d  = addr_q + SCORE_AW'(1);
              tone_d  = 1'b0;
            end else begin
              state_d = PLAY;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    speaker_d  = (state_d == PLAY) && !frozen && tone_d;
    busy_d     = (state_d != IDLE);
    cur_note_d = (state_d == PLAY) ? note_d : 6'd0;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      tick_q     <= '0;
      rem_q      <= 6'd0;
      gap_q      <= '0;
      phase_q    <= '0;
      note_q     <= 6'd0;
      tone_q     <= 1'b0;
      speaker_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cur_note_q <= 6'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      tick_q     <= tick_d;
      rem_q      <= rem_d;
      gap_q      <= gap_d;
      phase_q    <= phase_d;
      note_q     <= note_d;
      tone_q     <= tone_d;
      speaker_q  <= speaker_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cur_note_q <= cur_note_d;
    end
  end

  assign score_addr = addr_q;
  assign speaker    = speaker_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cur_note   = cur_note_q;

endmodule

// File: tb/tb_music_sequencer.sv
// Randomised bench for music_sequencer: an expected output timeline is built
// from the score with plain arithmetic and compared clock by clock.
module tb_music_sequencer;

  localparam int TICK     = 16;
  localparam int GAP      = 4;
  localparam int PRESC_TB = 2;

  typedef struct packed {
    logic       spk;
    logic       busy;
    logic       done;
    logic [5:0] note;
    logic [7:0] addr;
  } snap_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        pause = 1'b0;
  logic        loop_en = 1'b0;
  logic [1:0]  oct_shift = 2'd0;
  logic [7:0]  score_addr;
  logic [15:0] score_data;
  logic        speaker, busy, done;
  logic [5:0]  cur_note;

  logic [15:0] rom [256];
  snap_t       exp_q [$];
  int          checks = 0;
  int          passes = 0;
  int          base_tb [12] = '{511, 482, 455, 430, 405, 383, 361, 341, 322, 303, 286, 270};

  music_sequencer #(.SCORE_AW(8), .TICK_DIV(TICK), .GAP_CYC(GAP), .PRESC(PRESC_TB)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause), .loop_en(loop_en),
    .oct_shift(oct_shift), .score_addr(score_addr), .score_data(score_data),
    .speaker(speaker), .busy(busy), .done(done), .cur_note(cur_note)
  );

  always #5 clk = ~clk;

  always @(posedge clk) score_data <= rom[score_addr];

  function automatic logic [15:0] mk_entry(input int d, input int n);
    logic [15:0] w;
    w       = 16'($urandom);
    w[13:8] = 6'(d);
    w[5:0]  = 6'(n);
    return w;
  endfunction

  function automatic snap_t mk_snap(input bit s, input bit b, input bit d, input int n, input int a);
    snap_t r;
    r.spk = s; r.busy = b; r.done = d; r.note = 6'(n); r.addr = 8'(a);
    return r;
  endfunction

  function automatic int model_hp(input int n, input int sh);
    int eo, s;
    eo = n / 12 + sh;
    if (eo > 7) eo = 7;
    s = PRESC_TB - eo;
    if (s < 0) s = 0;
    return (base_tb[n % 12] + 1) << s;
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  // One snapshot per clock from start: FETCH, LOAD, dur*TICK play clocks, ...
  task automatic build(input bit lp, input int sh, input int max_len);
    int addr, dur, nt, hp;
    bit s;
    exp_q.delete();
    addr = 0;
    exp_q.push_back(mk_snap(1'b0, 1'b1, 1'b0, 0, addr));
    while (exp_q.size() < max_len) begin
      exp_q.push_back(mk_snap(1'b0, 1'b1, 1'b0, 0, addr));
      dur = int'(rom[addr][13:8]);
      nt  = int'(rom[addr][5:0]);
      if (dur == 0) begin
        if (lp) begin
          addr = 0;
          exp_q.push_back(mk_snap(1'b0, 1'b1, 1'b0, 0, addr));
        end else begin
          exp_q.push_back(mk_snap(1'b0, 1'b0, 1'b1, 0, 0));
          break;
        end
      end else begin
        hp = model_hp(nt, sh);
        for (int c = 0; c < dur * TICK; c++) begin
          s = (nt != 0) && (c >= GAP) && (((c - GAP) / hp) % 2 == 0);
          exp_q.push_back(mk_snap(s, 1'b1, 1'b0, nt, addr));
        end
        addr = (addr + 1) % 256;
        exp_q.push_back(mk_snap(1'b0, 1'b1, 1'b0, 0, addr));
      end
    end
  endtask

  // mode 0: plain, 1: random pause/start pulses, 2: pause edges 20..119
  task automatic run_tl(input string name, input int mode, input bit lp, input logic [1:0] sh);
    snap_t e, last, act;
    int k;
    bit paused;
    k = 0;
    last = '0;
    loop_en = lp;
    oct_shift = sh;
    start = 1'b1;
    pause = (mode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
    while (exp_q.size() > 0 && k < 20000) begin
      @(posedge clk);
      #1;
      paused = pause && (k > 0);
      if (paused) begin
        e = last;
        e.spk = 1'b0;
      end else begin
        e = exp_q.pop_front();
        last = e;
      end
      act = {speaker, busy, done, cur_note, score_addr};
      checks++;
      if (act !== e) begin
        $display("FAIL %s clk %0d: got spk=%b busy=%b done=%b note=%0d addr=%0d, expected spk=%b busy=%b done=%b note=%0d addr=%0d",
                 name, k, act.spk, act.busy, act.done, act.note, act.addr, e.spk, e.busy, e.done, e.note, e.addr);
      end else begin
        passes++;
      end
      k++;
      start = (mode == 1) ? ($urandom_range(0, 15) == 0) : 1'b0;
      if (mode == 1) pause = ($urandom_range(0, 7) == 0);
      else if (mode == 2) pause = (k >= 20 && k < 120);
      else pause = 1'b0;
    end
    checks++;
    if (exp_q.size() != 0) $display("FAIL %s timeout: %0d clocks left, expected 0", name, exp_q.size());
    else passes++;
    start = 1'b0;
    pause = 1'b0;
  endtask

  task automatic test_reset();
    snap_t act;
    rst = 1'b1;
    #2;
    act = {speaker, busy, done, cur_note, score_addr};
    checks++;
    if (act !== 17'd0) $display("FAIL reset_async: got %h, expected 0", act);
    else passes++;
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    act = {speaker, busy, done, cur_note, score_addr};
    checks++;
    if (act !== 17'd0) $display("FAIL reset_idle: got %h, expected 0", act);
    else passes++;
  endtask

  task automatic test_single_note();
    clear_rom();
    rom[0] = mk_entry(2, 3);
    rom[1] = mk_entry(0, 9);
    build(1'b0, 0, 5000);
    run_tl("single_note", 0, 1'b0, 2'd0);
  endtask

  task automatic test_octave();
    clear_rom();
    rom[0] = mk_entry(63, 15);
    build(1'b0, 1, 5000);
    run_tl("oct_note15_sh1", 0, 1'b0, 2'd1);
    rom[0] = mk_entry(63, 63);
    build(1'b0, 3, 5000);
    run_tl("oct_note63_sh3", 0, 1'b0, 2'd3);
  endtask

  task automatic test_rest();
    clear_rom();
    rom[0] = mk_entry(3, 0);
    build(1'b0, 0, 5000);
    run_tl("rest", 0, 1'b0, 2'd0);
  endtask

  task automatic test_loop_stop();
    snap_t act;
    clear_rom();
    rom[0] = mk_entry(1, 5);
    rom[1] = mk_entry(2, 30);
    build(1'b1, 2, 200);
    run_tl("loop", 0, 1'b1, 2'd2);
    stop = 1'b1;
    pause = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    pause = 1'b0;
    act = {speaker, busy, done, cur_note, score_addr};
    checks++;
    if (act !== 17'd0) $display("FAIL stop_over_pause: got %h, expected 0", act);
    else passes++;
    @(posedge clk);
    #1;
    act = {speaker, busy, done, cur_note, score_addr};
    checks++;
    if (act !== 17'd0) $display("FAIL stop_stays_idle: got %h, expected 0", act);
    else passes++;
  endtask

  task automatic test_pause();
    clear_rom();
    rom[0] = mk_entry(4, 40);
    build(1'b0, 0, 5000);
    run_tl("pause_window", 2, 1'b0, 2'd0);
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 5; it++) begin
      clear_rom();
      n = $urandom_range(2, 5);
      for (int i = 0; i < n; i++) begin
        rom[i] = mk_entry($urandom_range(1, 3), ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 63));
      end
      rom[n] = mk_entry(0, $urandom_range(0, 63));
      oct_shift = 2'($urandom_range(0, 3));
      build(1'b0, int'(oct_shift), 5000);
      run_tl("random", 1, 1'b0, oct_shift);
    end
  endtask

  task automatic test_start_stop();
    snap_t act;
    for (int i = 0; i < 2; i++) begin
      start = (i == 0);
      stop  = (i == 0);
      @(posedge clk);
      #1;
      act = {speaker, busy, done, cur_note, score_addr};
      checks++;
      if (act !== 17'd0) $display("FAIL start_stop_same_cycle clk %0d: got %h, expected 0", i, act);
      else passes++;
    end
    start = 1'b0;
    stop = 1'b0;
  endtask

  task automatic test_async_reset();
    snap_t act;
    clear_rom();
    rom[0] = mk_entry(4, 20);
    loop_en = 1'b0;
    oct_shift = 2'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checks++;
    if (speaker !== 1'b1 || cur_note !== 6'd20) $display("FAIL pre_reset_tone: got spk=%b note=%0d, expected spk=1 note=20", speaker, cur_note);
    else passes++;
    #2 rst = 1'b1;
    #1;
    act = {speaker, busy, done, cur_note, score_addr};
    checks++;
    if (act !== 17'd0) $display("FAIL async_reset_immediate: got %h, expected 0", act);
    else passes++;
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      act = {speaker, busy, done, cur_note, score_addr};
      checks++;
      if (act !== 17'd0) $display("FAIL after_reset_quiet clk %0d: got %h, expected 0", i, act);
      else passes++;
    end
  endtask

  initial begin
    clear_rom();
    test_reset();
    test_single_note();
    test_octave();
    test_rest();
    test_loop_stop();
    test_pause();
    test_random();
    test_start_stop();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
